// File: rtl/bp_nonsynth_commit_matcher_if.sv
// Bundle between the commit/writeback producers, the matched-record consumer and the matcher.
// The master side drives commits, writebacks, the cap and yumi; the slave side is the matcher.
interface bp_nonsynth_commit_matcher_if
  #(parameter int num_rf_p      = 2
  , parameter int rf_els_p      = 32
  , parameter int vaddr_width_p = 39
  , parameter int instr_width_p = 32
  , parameter int data_width_p  = 64
  , parameter int cnt_width_p   = 32
  );

  localparam int rf_sel_w = (num_rf_p > 1) ? $clog2(num_rf_p) : 1;
  localparam int rd_w     = (rf_els_p > 1) ? $clog2(rf_els_p) : 1;

  logic                         commit_instret_i;
  logic                         commit_trap_i;
  logic                         commit_debug_i;
  logic [vaddr_width_p-1:0]     commit_pc_i;
  logic [instr_width_p-1:0]     commit_instr_i;
  logic                         commit_rd_w_v_i;
  logic [rf_sel_w-1:0]          commit_rf_sel_i;
  logic [data_width_p-1:0]      commit_cause_i;

  logic [num_rf_p-1:0]          wb_v_i;
  logic [num_rf_p*rd_w-1:0]     wb_addr_i;
  logic [num_rf_p*data_width_p-1:0] wb_data_i;

  logic [cnt_width_p-1:0]       instr_cap_i;

  logic                         out_v_o;
  logic                         out_yumi_i;
  logic [vaddr_width_p-1:0]     out_pc_o;
  logic [instr_width_p-1:0]     out_instr_o;
  logic                         out_debug_o;
  logic                         out_trap_o;
  logic [data_width_p-1:0]      out_cause_o;
  logic                         out_rd_w_v_o;
  logic [rf_sel_w-1:0]          out_rf_sel_o;
  logic [data_width_p-1:0]      out_data_o;

  logic [cnt_width_p-1:0]       instr_cnt_o;
  logic                         done_o;
  logic                         overflow_o;
  logic                         timeout_o;

  modport master
    (output commit_instret_i, commit_trap_i, commit_debug_i, commit_pc_i, commit_instr_i
   , output commit_rd_w_v_i, commit_rf_sel_i, commit_cause_i
   , output wb_v_i, wb_addr_i, wb_data_i, instr_cap_i, out_yumi_i
   , input  out_v_o, out_pc_o, out_instr_o, out_debug_o, out_trap_o, out_cause_o
   , input  out_rd_w_v_o, out_rf_sel_o, out_data_o
   , input  instr_cnt_o, done_o, overflow_o, timeout_o
   );

  modport slave
    (input  commit_instret_i, commit_trap_i, commit_debug_i, commit_pc_i, commit_instr_i
   , input  commit_rd_w_v_i, commit_rf_sel_i, commit_cause_i
   , input  wb_v_i, wb_addr_i, wb_data_i, instr_cap_i, out_yumi_i
   , output out_v_o, out_pc_o, out_instr_o, out_debug_o, out_trap_o, out_cause_o
   , output out_rd_w_v_o, out_rf_sel_o, out_data_o
   , output instr_cnt_o, done_o, overflow_o, timeout_o
   );

endinterface

// File: rtl/bp_nonsynth_commit_matcher.sv
// Pairs in-order committed instructions with their per-register writeback data and
// emits one data-complete retire record per yumi, plus retire count, cap, overflow and stall flags.
module bp_nonsynth_commit_matcher
  #(parameter int num_rf_p      = 2
  , parameter int rf_els_p      = 32
  , parameter int vaddr_width_p = 39
  , parameter int instr_width_p = 32
  , parameter int data_width_p  = 64
  , parameter int commit_els_p  = 16
  , parameter int wb_els_p      = 4
  , parameter int timeout_p     = 1024
  , parameter int cnt_width_p   = 32
  )
  (input logic clk_i
  , input logic reset_i
  , bp_nonsynth_commit_matcher_if.slave io
  );

  localparam int rf_sel_w = (num_rf_p > 1) ? $clog2(num_rf_p) : 1;
  localparam int rd_w     = (rf_els_p > 1) ? $clog2(rf_els_p) : 1;
  localparam int c_ptr_w  = $clog2(commit_els_p);
  localparam int wb_ptr_w = $clog2(wb_els_p);
  localparam int wait_w   = $clog2(timeout_p + 1);

  localparam logic [c_ptr_w:0]       c_inc    = 1;
  localparam logic [wb_ptr_w:0]      wb_inc   = 1;
  localparam logic [wait_w-1:0]      wait_inc = 1;
  localparam logic [wait_w-1:0]      wait_max = wait_w'(timeout_p);
  localparam logic [cnt_width_p-1:0] cnt_inc  = 1;

  typedef struct packed {
    logic                     instret;
    logic                     trap;
    logic                     debug;
    logic                     rd_w_v;
    logic [rf_sel_w-1:0]      rf_sel;
    logic [vaddr_width_p-1:0] pc;
    logic [instr_width_p-1:0] instr;
    logic [data_width_p-1:0]  cause;
  } commit_rec_t;

  commit_rec_t             commit_mem [commit_els_p];
  logic [data_width_p-1:0] wb_mem     [num_rf_p][rf_els_p][wb_els_p];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_ptr_w:0]  c_wptr, c_rptr;
  logic [wb_ptr_w:0] wb_wptr [num_rf_p][rf_els_p];
  logic [wb_ptr_w:0] wb_rptr [num_rf_p][rf_els_p];

  commit_rec_t             commit_in, head;
  logic                    commit_push, commit_push_ok, c_empty, c_full;
  logic [rd_w-1:0]         head_rd;
  logic [wb_ptr_w:0]       head_wb_wptr, head_wb_rptr;
  logic                    head_wb_v, head_ready, pop, pop_wb;
  logic [rd_w-1:0]         wb_addr [num_rf_p];
  logic [data_width_p-1:0] wb_data [num_rf_p];
  logic [num_rf_p-1:0]     wb_full, wb_push_ok;
  logic [wait_w-1:0]       wait_cnt, wait_next;
  logic [cnt_width_p-1:0]  instr_cnt;
  logic                    done_q, overflow_q, timeout_q;

  always_comb begin
    commit_push    = io.commit_instret_i | io.commit_trap_i;
    c_empty        = (c_wptr == c_rptr);
    c_full         = (c_wptr[c_ptr_w] != c_rptr[c_ptr_w])
                   && (c_wptr[c_ptr_w-1:0] == c_rptr[c_ptr_w-1:0]);
    commit_push_ok = commit_push & ~c_full;

    // A trap wins over a simultaneous retire, so it never waits for writeback data.
    commit_in.instret = io.commit_instret_i;
    commit_in.trap    = io.commit_trap_i;
    commit_in.debug   = io.commit_debug_i;
    commit_in.rd_w_v  = io.commit_rd_w_v_i & io.commit_instret_i & ~io.commit_trap_i;
    commit_in.rf_sel  = io.commit_rf_sel_i;
    commit_in.pc      = io.commit_pc_i;
    commit_in.instr   = io.commit_instr_i;
    commit_in.cause   = io.commit_cause_i;

    head         = commit_mem[c_rptr[c_ptr_w-1:0]];
    head_rd      = rd_w'(head.instr[11:7]);
    head_wb_wptr = wb_wptr[head.rf_sel][head_rd];
    head_wb_rptr = wb_rptr[head.rf_sel][head_rd];
    head_wb_v    = (head_wb_wptr != head_wb_rptr);
    head_ready   = ~c_empty & (~head.rd_w_v | head_wb_v);
    pop          = head_ready & io.out_yumi_i;
    pop_wb       = pop & head.rd_w_v;
  end

  always_comb begin
    wb_addr    = '{default: '0};
    wb_data    = '{default: '0};
    wb_full    = '0;
    wb_push_ok = '0;
    for (int f = 0; f < num_rf_p; f++) begin
      wb_addr[f]    = io.wb_addr_i[f*rd_w +: rd_w];
      wb_data[f]    = io.wb_data_i[f*data_width_p +: data_width_p];
      wb_full[f]    = (wb_wptr[f][wb_addr[f]][wb_ptr_w] != wb_rptr[f][wb_addr[f]][wb_ptr_w])
                    && (wb_wptr[f][wb_addr[f]][wb_ptr_w-1:0] == wb_rptr[f][wb_addr[f]][wb_ptr_w-1:0]);
      wb_push_ok[f] = io.wb_v_i[f] & ~wb_full[f];
    end
  end

  // Only a head stalled on missing data ages; a ready head held by the consumer does not.
  always_comb begin
    wait_next = '0;
    if (~c_empty & ~head_ready)
      wait_next = (wait_cnt == wait_max) ? wait_cnt : wait_cnt + wait_inc;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      c_wptr     <= '0;
      c_rptr     <= '0;
      for (int f = 0; f < num_rf_p; f++)
        for (int r = 0; r < rf_els_p; r++) begin
          wb_wptr[f][r] <= '0;
          wb_rptr[f][r] <= '0;
        end
      wait_cnt   <= '0;
      instr_cnt  <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (commit_push_ok) c_wptr <= c_wptr + c_inc;
      if (pop)            c_rptr <= c_rptr + c_inc;
      for (int f = 0; f < num_rf_p; f++)
        if (wb_push_ok[f]) wb_wptr[f][wb_addr[f]] <= wb_wptr[f][wb_addr[f]] + wb_inc;
      if (pop_wb)
        wb_rptr[head.rf_sel][head_rd] <= head_wb_rptr + wb_inc;

      if (pop && head.instret && !head.trap && !head.debug && (instr_cnt != '1))
        instr_cnt <= instr_cnt + cnt_inc;
      if ((io.instr_cap_i != '0) && (instr_cnt == io.instr_cap_i))
        done_q <= 1'b1;
      if ((commit_push & c_full) | (|(io.wb_v_i & wb_full)))
        overflow_q <= 1'b1;
      wait_cnt <= wait_next;
      if (wait_next == wait_max)
        timeout_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit_push_ok)
      commit_mem[c_wptr[c_ptr_w-1:0]] <= commit_in;
    for (int f = 0; f < num_rf_p; f++)
      if (wb_push_ok[f])
        wb_mem[f][wb_addr[f]][wb_wptr[f][wb_addr[f]][wb_ptr_w-1:0]] <= wb_data[f];
  end

  // Record fields are zeroed whenever no record is offered, so reset clears them instantly.
  assign io.out_v_o      = head_ready;
  assign io.out_pc_o     = head_ready ? head.pc     : '0;
  assign io.out_instr_o  = head_ready ? head.instr  : '0;
  assign io.out_debug_o  = head_ready & head.debug;
  assign io.out_trap_o   = head_ready & head.trap;
  assign io.out_cause_o  = head_ready ? head.cause  : '0;
  assign io.out_rd_w_v_o = head_ready & head.rd_w_v;
  assign io.out_rf_sel_o = head_ready ? head.rf_sel : '0;
  assign io.out_data_o   = (head_ready && head.rd_w_v)
                         ? wb_mem[head.rf_sel][head_rd][head_wb_rptr[wb_ptr_w-1:0]] : '0;
  assign io.instr_cnt_o  = instr_cnt;
  assign io.done_o       = done_q;
  assign io.overflow_o   = overflow_q;
  assign io.timeout_o    = timeout_q;

endmodule

// File: doc/bp_nonsynth_commit_matcher.md
Name: bp_nonsynth_commit_matcher

Overview:
Parametrised commit/writeback pairing engine for cosim and trace back-ends.
- Buffers committed instructions and traps in a commit FIFO.
- Holds per-register writeback data for num_rf_p register files.
- Emits one matched retire record per handshake once the head's destination writeback has arrived.
- Adds retire counting, instruction-cap completion, overflow detection and a stall watchdog, so DPI consumers only see in-order, data-complete records.

Parameters:
num_rf_p, 2, number of register files (0 = int, 1 = fp, ...), each with one writeback port
rf_els_p, 32, registers per file; rd address width = clog2(rf_els_p)
vaddr_width_p, 39, PC width
instr_width_p, 32, instruction width; rd field = instr[11:7]
data_width_p, 64, writeback data / cause width
commit_els_p, 16, commit FIFO depth (power of 2, >= 2)
wb_els_p, 4, per-register writeback FIFO depth (power of 2, >= 2)
timeout_p, 1024, head-wait cycles before timeout_o asserts
cnt_width_p, 32, retire counter width

Ports:
clk_i  in  1  clock, posedge
reset_i  in  1  reset, asynchronous, active-low
commit_instret_i  in  1  instruction retires this cycle
commit_trap_i  in  1  exception/interrupt taken this cycle
commit_debug_i  in  1  commit occurred in debug mode
commit_pc_i  in  vaddr_width_p  committed PC
commit_instr_i  in  instr_width_p  committed instruction
commit_rd_w_v_i  in  1  instruction writes a destination register
commit_rf_sel_i  in  clog2(num_rf_p)  destination register file
commit_cause_i  in  data_width_p  trap cause
wb_v_i  in  num_rf_p  writeback valid, per file
wb_addr_i  in  num_rf_p*clog2(rf_els_p)  writeback register address
wb_data_i  in  num_rf_p*data_width_p  writeback data
instr_cap_i  in  cnt_width_p  retire cap; 0 = no cap
out_v_o  out  1  matched record valid
out_yumi_i  in  1  consumer takes record; legal only while out_v_o
out_pc_o, out_instr_o, out_debug_o, out_trap_o, out_cause_o  out  as above  head record fields
out_rd_w_v_o  out  1  record carries writeback data
out_rf_sel_o  out  clog2(num_rf_p)  register file of out_data_o
out_data_o  out  data_width_p  matched writeback data; 0 when out_rd_w_v_o=0
instr_cnt_o  out  cnt_width_p  non-debug retired count
done_o  out  1  sticky, cap reached
overflow_o  out  1  sticky, any FIFO push dropped
timeout_o  out  1  sticky, head waited timeout_p cycles

Behaviour:
- Reset (reset_i=0, async): all FIFOs empty, counters 0; out_v_o, done_o, overflow_o, timeout_o, instr_cnt_o = 0. Release is synchronous to the next posedge.
- Commit push: fires when commit_instret_i | commit_trap_i.
  - Stored rd_w_v = commit_rd_w_v_i & commit_instret_i & ~commit_trap_i.
  - Trap with instret: the trap wins and no writeback is expected.
- Writeback push: per file f, wb_v_i[f] pushes wb_data into FIFO [f][wb_addr]. Multiple files push in the same cycle independently.
- Full FIFO: a push is dropped and overflow_o sets, even if a pop occurs in the same cycle. Queue contents are unaffected.
- Head ready = commit FIFO non-empty & (~rd_w_v | wb FIFO[rf_sel][instr[11:7]] non-empty).
- out_v_o = head ready. Outputs are driven combinationally from FIFO heads.
- Latency:
  - Commit and matching writeback at posedge t: out_v_o at t+1.
  - Writeback arriving later at t': out_v_o at t'+1.
- Pop on out_yumi_i: pops the commit FIFO and, if rd_w_v, the matched writeback FIFO. Writebacks to the same register drain in order.
- Push and pop on the same non-full FIFO in one cycle: both take effect and occupancy is unchanged.
- instr_cnt_o: +1 on pop with instret & ~trap & ~debug; saturates at all-ones.
- done_o: sets the cycle after instr_cnt_o == instr_cap_i with instr_cap_i != 0; sticky until reset.
- Watchdog:
  - wait_cnt increments each cycle the commit FIFO is non-empty and the head is not ready.
  - Clears when the head is ready.
  - Saturates at timeout_p; timeout_o sets when it reaches timeout_p.
  - A consumer withholding yumi never counts.
- Reset mid-operation: everything drops immediately, including in-flight records and sticky flags.

Test Plan:
- Commit pc=0x80000000, addi x5 (rd_w_v, rf 0) with wb_v[0], addr 5, data 0x2A in the same cycle -> next cycle out_v_o=1, out_data_o=0x2A; yumi -> instr_cnt_o=1.
- Commit fld f3 (rf 1) at cycle 0, fp wb addr 3 data 0x3FF0000000000000 at cycle 10 -> out_v_o=0 during cycles 1-10, 1 at cycle 11 with that data; timeout_o stays 0.
- Two writebacks to x7 (0x1, then 0x2) followed by two commits writing x7 -> records emitted in order with 0x1 then 0x2.
- Trap with commit_trap_i=1, instret=1, cause 0x2 -> record with out_trap_o=1, out_rd_w_v_o=0, out_cause_o=0x2; instr_cnt_o unchanged.
- 17 commits with yumi held low, commit_els_p=16 -> overflow_o=1 after the 17th; exactly 16 records drain later.
- instr_cap_i=3, three non-debug retires plus one debug retire -> done_o=1 one cycle after the third non-debug pop.
- Commit needing x9 with no writeback and timeout_p=8 -> timeout_o=1 8 cycles after out_v_o would have been possible.
- Assert reset mid-drain -> all outputs 0 immediately.
